instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_pkg.sv | 13 +
 rtl/instr_queue.sv | 78 +++++++
 tb/tb_instr_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/instr_queue_pkg.sv
// Shared types for the front-end instruction path: the fetch record that
// travels from instr_fetch to decode, and the default queue depth.
package instr_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] raw;
    } fetch_rec_t;

    localparam int FETCH_REC_W       = $bits(fetch_rec_t);
    localparam int INSTR_QUEUE_DEPTH = 4;

endpackage

// File: rtl/instr_queue.sv
// Circular-buffer queue decoupling instruction fetch from decode; minimum
// latency one cycle, flush and reset empty it.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = INSTR_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_fetched_valid,
    output logic                       o_fetched_ready,
    input  logic [FETCH_REC_W-1:0]     i_fetched_data,
    output logic                       o_issue_valid,
    input  logic                       i_issue_ready,
    output logic [FETCH_REC_W-1:0]     o_issue_data,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, ready never waits on valid.
    fetch_rec_t        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_enq;
    logic              w_deq;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A full queue never accepts in the cycle it drains: ready looks only at
    // the registered count, not at the dequeue happening alongside.
    assign o_fetched_ready = !w_full && !i_flush;
    assign o_issue_valid   = !w_empty && !i_flush;
    assign o_issue_data    = r_mem[r_head];
    assign o_count         = r_count;

    assign w_enq = i_fetched_valid && o_fetched_ready;
    assign w_deq = o_issue_valid && i_issue_ready;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= fetch_rec_t'(i_fetched_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: drivers push expected records as they are
// accepted, an independent monitor pops and compares on every issue transfer.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int W = FETCH_REC_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         i_fetched_valid = 1'b0;
  logic         o_fetched_ready;
  logic [W-1:0] i_fetched_data = '0;
  logic         o_issue_valid;
  logic         i_issue_ready = 1'b0;
  logic [W-1:0] o_issue_data;
  logic         i_flush = 1'b0;
  logic [2:0]   o_count;

  instr_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_fetched_valid (i_fetched_valid),
    .o_fetched_ready (o_fetched_ready),
    .i_fetched_data  (i_fetched_data),
    .o_issue_valid   (o_issue_valid),
    .i_issue_ready   (i_issue_ready),
    .o_issue_data    (o_issue_data),
    .i_flush         (i_flush),
    .o_count         (o_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] rec(input logic [31:0] pc, input logic [31:0] raw);
    fetch_rec_t r;
    r.pc  = pc;
    r.raw = raw;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int cnt, input int vld, input int rdy);
    check({name, ".count"}, int'(o_count), cnt);
    check({name, ".issue_valid"}, int'(o_issue_valid), vld);
    check({name, ".fetched_ready"}, int'(o_fetched_ready), rdy);
  endtask

  // One clock of stimulus; returns #1 after the rising edge.
  task automatic step(input logic fv, input logic [W-1:0] d, input logic ir, input logic fl);
    i_fetched_valid = fv;
    i_fetched_data  = d;
    i_issue_ready   = ir;
    i_flush         = fl;
    @(negedge clk);
    if (fl) exp_q.delete();
    else if (fv && o_fetched_ready) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && o_issue_valid && i_issue_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got %h expected no transfer", o_issue_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (o_issue_data !== e) begin
          n_fail++;
          $display("FAIL issue_data: got %h expected %h", o_issue_data, e);
        end
      end
    end
  end

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 1);
    rst = 1'b0;
    #1;
    check_state("after_reset", 0, 0, 1);

    // single push, one-cycle latency
    step(1'b1, rec(32'h1000, 32'h0000_0013), 1'b0, 1'b0);
    i_fetched_valid = 1'b0;
    #1;
    check_state("first_push", 1, 1, 1);
    check("first_push.data_pc", int'(o_issue_data[63:32]), 32'h1000);
    check("first_push.data_raw", int'(o_issue_data[31:0]), 32'h13);
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("first_pop", 0, 0, 1);

    // fill to DEPTH, fifth refused, head stays stable
    for (int i = 0; i < 4; i++)
      step(1'b1, rec(32'h2000 + 32'(4 * i), 32'h100 + 32'(i)), 1'b0, 1'b0);
    check_state("full", 4, 1, 0);
    step(1'b1, rec(32'hDEAD, 32'hBEEF), 1'b0, 1'b0);
    check_state("full_refuse", 4, 1, 0);
    check("full_stable.pc", int'(o_issue_data[63:32]), 32'h2000);

    // full: deq and offered enq in the same cycle -> only deq
    step(1'b1, rec(32'h3000, 32'h200), 1'b1, 1'b0);
    check_state("full_deq", 3, 1, 1);
    step(1'b1, rec(32'h3000, 32'h200), 1'b0, 1'b0);
    check_state("refill", 4, 1, 0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_state("drained", 0, 0, 1);

    // 10 back-to-back with both sides ready
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rec(32'h4000 + 32'(4 * i), 32'h300 + 32'(i)), 1'b1, 1'b0);
      check("stream.count", int'(o_count), 1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("stream_end", 0, 0, 1);

    // flush with both sides offering
    for (int i = 0; i < 3; i++)
      step(1'b1, rec(32'h5000 + 32'(i), 32'h400 + 32'(i)), 1'b0, 1'b0);
    check_state("pre_flush", 3, 1, 1);
    i_fetched_valid = 1'b1;
    i_fetched_data  = rec(32'h5555, 32'h5555);
    i_issue_ready   = 1'b1;
    i_flush         = 1'b1;
    #1;
    check("flush.no_ready", int'(o_fetched_ready), 0);
    check("flush.no_valid", int'(o_issue_valid), 0);
    step(1'b1, rec(32'h5555, 32'h5555), 1'b1, 1'b1);
    i_fetched_valid = 1'b0;
    i_issue_ready   = 1'b0;
    i_flush         = 1'b0;
    #1;
    check_state("post_flush", 0, 0, 1);
    step(1'b1, rec(32'h6000, 32'h500), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("post_flush_pop", 0, 0, 1);

    // async reset mid-stream
    step(1'b1, rec(32'h7000, 32'h600), 1'b0, 1'b0);
    step(1'b1, rec(32'h7004, 32'h601), 1'b0, 1'b0);
    i_fetched_valid = 1'b0;
    #1;
    check_state("pre_rst", 2, 1, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_state("async_rst", 0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, rec(32'h8000, 32'h700), 1'b0, 1'b0);
    check_state("post_rst_push", 1, 1, 1);
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("post_rst_pop", 0, 0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
